branch_resolve_queue: RTL and testbench
=======================================

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 Parameter PC_WIDTH, default 32, width of all PC and target buses.
REQ-002 Parameter DEPTH, default 4, number of in-flight branch entries (power of two, at least 2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 push_valid  input  1  fetch stage records a predicted branch this cycle.
REQ-006 push_pc  input  PC_WIDTH  PC of the branch being recorded.
REQ-007 push_pred_taken  input  1  predicted direction for the recorded branch.
REQ-008 push_pred_target  input  PC_WIDTH  predicted target for the recorded branch.
REQ-009 push_ready  output  1  queue can accept a push (not full).
REQ-010 res_valid  input  1  execute stage resolves the oldest in-flight branch.
REQ-011 res_taken  input  1  resolved direction.
REQ-012 res_target  input  PC_WIDTH  resolved taken target.
REQ-013 actual_valid  output  1  registered resolution strobe for speculation control.
REQ-014 actual_taken  output  1  registered resolved direction.
REQ-015 actual_target  output  PC_WIDTH  registered resolved target.
REQ-016 predicted_taken  output  1  registered prediction of the resolved entry.
REQ-017 mispredict  output  1  registered one-cycle mispredict pulse.
REQ-018 recover_pc  output  PC_WIDTH  correct next PC for the resolved branch.
REQ-019 upd_valid, upd_pc, upd_taken  output  1/PC_WIDTH/1  predictor training update.
REQ-020 count  output  clog2(DEPTH)+1  current occupancy.
REQ-021 err_underflow  output  1  sticky flag: resolution arrived while the queue was empty.

Function
REQ-022 The queue SHALL be an in-order FIFO of {pc, pred_taken, pred_target}, with read and write pointers that wrap modulo DEPTH.
REQ-023 push_ready SHALL be high exactly when count is less than DEPTH; a push with push_ready low SHALL be dropped and leave state unchanged.
REQ-024 When res_valid is high and count is nonzero, the head entry SHALL be popped, and all registered outputs SHALL update on the same edge (one-cycle latency).
REQ-025 mispredict SHALL be set when pred_taken differs from res_taken, or when both are taken and pred_target differs from res_target.
REQ-026 recover_pc SHALL equal res_target if res_taken, else head pc + 4, truncated to PC_WIDTH; it SHALL hold its value until the next resolution.
REQ-027 upd_valid SHALL pulse for every valid resolution, with upd_pc set to head pc and upd_taken set to res_taken.
REQ-028 On a mispredict, all younger entries SHALL be discarded (count becomes 0); a push in the same cycle SHALL be dropped as wrong-path.
REQ-029 A simultaneous push and correct-prediction pop SHALL leave count unchanged, and SHALL be accepted even when full.
REQ-030 res_valid with count equal to 0 SHALL produce no strobe and SHALL set err_underflow, which clears only on reset.
REQ-031 actual_valid, mispredict and upd_valid SHALL be single-cycle pulses, low in any cycle without a valid resolution.

Reset
REQ-032 Assertion of reset SHALL immediately clear both pointers, count, all pulses, err_underflow, recover_pc, actual_target, actual_taken and predicted_taken to 0, regardless of clk.
REQ-033 After reset deasserts, push_ready SHALL be high and the first accepted push SHALL occur on the next rising edge.

Structure
REQ-034 PC_WIDTH default, DEPTH default and the entry record type SHALL reside in the shared pipeline package.
REQ-035 The FIFO storage and pointer logic SHALL be one sub-module, bq_fifo; compare, recovery and output registers SHALL stay at top level.

Verification
REQ-036 Push {0x100, taken, 0x200}, then resolve taken with target 0x200 -> one cycle later: actual_valid=1, mispredict=0, recover_pc=0x200, upd_pc=0x100.
REQ-037 Push {0x100, not-taken}, then resolve taken with target 0x180 -> mispredict=1, recover_pc=0x180, count=0.
REQ-038 Push {0x104, taken, 0x300} and {0x108, ...}, then resolve not-taken -> mispredict=1, recover_pc=0x108, second entry discarded, count=0.
REQ-039 Push 4 entries (DEPTH=4) -> push_ready=0, and a fifth push is dropped; push and correct pop in the same cycle keep count=4; pointer wrap is verified over 10 entries.
REQ-040 res_valid with an empty queue -> no actual_valid, err_underflow=1 and sticky; reset mid-operation with 3 entries -> count=0, outputs 0, asynchronously.

Source files
------------

// File: rtl/branch_resolve_queue_pkg.sv
// Shared pipeline definitions for the branch resolve queue.
package branch_resolve_queue_pkg;

    localparam int unsigned BQ_PC_WIDTH = 32;
    localparam int unsigned BQ_DEPTH    = 4;

    // One in-flight predicted branch, oldest-first in the queue.
    typedef struct packed {
        logic [BQ_PC_WIDTH-1:0] pc;
        logic                   pred_taken;
        logic [BQ_PC_WIDTH-1:0] pred_target;
    } bq_entry_t;

endpackage

// File: rtl/branch_resolve_queue_fifo.sv
// In-order entry storage with wrapping pointers, occupancy and flush.
module bq_fifo
    import branch_resolve_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = BQ_DEPTH,
    parameter type         entry_t = bq_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  entry_t                 wr_data,
    input  logic                   rd_en,
    input  logic                   flush,
    output entry_t                 rd_data_c,
    output logic [$clog2(DEPTH):0] count,
    output logic                   not_full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count_nxt;

    assign rd_data_c = mem[rd_ptr];

    // Next occupancy; a flush empties the queue regardless of other traffic.
    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (wr_en && !rd_en) begin
            count_nxt = count + CW'(1);
        end else if (!wr_en && rd_en) begin
            count_nxt = count - CW'(1);
        end
    end

    // Pointers, occupancy and registered not-full flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            not_full <= 1'b1;
        end else begin
            count    <= count_nxt;
            not_full <= (count_nxt < CW'(DEPTH));
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (rd_en) rd_ptr <= rd_ptr + PW'(1);
                if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            end
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// Tracks predicted branches in flight and compares them against resolutions.
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int unsigned PC_WIDTH = BQ_PC_WIDTH,
    parameter int unsigned DEPTH    = BQ_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_valid,
    input  logic [PC_WIDTH-1:0]    push_pc,
    input  logic                   push_pred_taken,
    input  logic [PC_WIDTH-1:0]    push_pred_target,
    output logic                   push_ready,
    input  logic                   res_valid,
    input  logic                   res_taken,
    input  logic [PC_WIDTH-1:0]    res_target,
    output logic                   actual_valid,
    output logic                   actual_taken,
    output logic [PC_WIDTH-1:0]    actual_target,
    output logic                   predicted_taken,
    output logic                   mispredict,
    output logic [PC_WIDTH-1:0]    recover_pc,
    output logic                   upd_valid,
    output logic [PC_WIDTH-1:0]    upd_pc,
    output logic                   upd_taken,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_underflow
);

    // Same field layout as bq_entry_t, sized to this instance's PC width.
    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic                pred_taken;
        logic [PC_WIDTH-1:0] pred_target;
    } entry_t;

    entry_t              head_c;
    entry_t              push_entry_c;
    logic                pop_c;
    logic                mispred_c;
    logic                flush_c;
    logic                push_accept_c;
    logic [PC_WIDTH-1:0] recover_c;

    // Resolution compare, recovery PC and push acceptance.
    always_comb begin
        push_entry_c.pc          = push_pc;
        push_entry_c.pred_taken  = push_pred_taken;
        push_entry_c.pred_target = push_pred_target;
        pop_c         = res_valid && (count != '0);
        mispred_c     = (head_c.pred_taken != res_taken) ||
                        (res_taken && (head_c.pred_target != res_target));
        flush_c       = pop_c && mispred_c;
        recover_c     = res_taken ? res_target : (head_c.pc + PC_WIDTH'(4));
        // A full queue still takes a push when a correct pop frees a slot.
        push_accept_c = push_valid && !flush_c && (push_ready || pop_c);
    end

    bq_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (push_accept_c),
        .wr_data   (push_entry_c),
        .rd_en     (pop_c),
        .flush     (flush_c),
        .rd_data_c (head_c),
        .count     (count),
        .not_full  (push_ready)
    );

    // Registered resolution outputs, training update and sticky underflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            actual_valid    <= 1'b0;
            actual_taken    <= 1'b0;
            actual_target   <= '0;
            predicted_taken <= 1'b0;
            mispredict      <= 1'b0;
            recover_pc      <= '0;
            upd_valid       <= 1'b0;
            upd_pc          <= '0;
            upd_taken       <= 1'b0;
            err_underflow   <= 1'b0;
        end else begin
            actual_valid <= pop_c;
            mispredict   <= flush_c;
            upd_valid    <= pop_c;
            if (pop_c) begin
                actual_taken    <= res_taken;
                actual_target   <= res_target;
                predicted_taken <= head_c.pred_taken;
                recover_pc      <= recover_c;
                upd_pc          <= head_c.pc;
                upd_taken       <= res_taken;
            end
            if (res_valid && (count == '0)) err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue at PC_WIDTH=32, DEPTH=4.
module tb_branch_resolve_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        push_valid;
    logic [31:0] push_pc;
    logic        push_pred_taken;
    logic [31:0] push_pred_target;
    logic        push_ready;
    logic        res_valid;
    logic        res_taken;
    logic [31:0] res_target;
    logic        actual_valid;
    logic        actual_taken;
    logic [31:0] actual_target;
    logic        predicted_taken;
    logic        mispredict;
    logic [31:0] recover_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [2:0]  count;
    logic        err_underflow;

    branch_resolve_queue #(.PC_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .push_valid       (push_valid),
        .push_pc          (push_pc),
        .push_pred_taken  (push_pred_taken),
        .push_pred_target (push_pred_target),
        .push_ready       (push_ready),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .actual_valid     (actual_valid),
        .actual_taken     (actual_taken),
        .actual_target    (actual_target),
        .predicted_taken  (predicted_taken),
        .mispredict       (mispredict),
        .recover_pc       (recover_pc),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .count            (count),
        .err_underflow    (err_underflow)
    );

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
    } ent_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic        pred;
        logic        mis;
        logic [31:0] rpc;
        logic [31:0] upc;
        logic        utaken;
    } res_t;

    ent_t mq[$];
    res_t sb[$];
    res_t got;
    res_t exp_r;
    logic exp_err;
    int   vectors;
    int   miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle, updates the reference queue and queues the expected resolution.
    task automatic drive(input logic pv, input logic [31:0] ppc, input logic ppt,
                         input logic [31:0] ptgt, input logic rv, input logic rt,
                         input logic [31:0] rtgt);
        ent_t h;
        res_t r;
        logic pop;
        logic mis;
        logic acc;
        int   sz;
        push_valid = pv; push_pc = ppc; push_pred_taken = ppt; push_pred_target = ptgt;
        res_valid = rv; res_taken = rt; res_target = rtgt;
        sz  = mq.size();
        pop = rv && (sz != 0);
        mis = 1'b0;
        if (rv && sz == 0) exp_err = 1'b1;
        if (pop) begin
            h   = mq[0];
            mis = (h.pt != rt) || (rt && (h.tgt != rtgt));
            r.taken = rt; r.target = rtgt; r.pred = h.pt; r.mis = mis;
            r.rpc = rt ? rtgt : h.pc + 32'd4; r.upc = h.pc; r.utaken = rt;
            sb.push_back(r);
            if (mis) mq.delete();
            else mq.delete(0);
        end
        acc = pv && !(pop && mis) && ((sz < DEPTH) || (pop && !mis));
        if (acc) begin
            h.pc = ppc; h.pt = ppt; h.tgt = ptgt;
            mq.push_back(h);
        end
        @(posedge clk);
        #1;
        push_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        drive(1'b1, pc, pt, tgt, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic resolve(input logic rt, input logic [31:0] tgt);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, rt, tgt);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        push_valid = 1'b0; push_pc = '0; push_pred_taken = 1'b0; push_pred_target = '0;
        res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
        exp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
        vectors++;
        if (push_ready !== 1'b1) begin miscompares++; $display("FAIL reset_push_ready: got %b want 1", push_ready); end
        vectors++;
        if ({actual_valid, mispredict, upd_valid, err_underflow} !== 4'b0000)
            begin miscompares++; $display("FAIL reset_flags: got %b want 0000", {actual_valid, mispredict, upd_valid, err_underflow}); end
        vectors++;
        if (recover_pc !== 32'h0) begin miscompares++; $display("FAIL reset_recover_pc: got %h want 0", recover_pc); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_correct();
        push(32'h100, 1'b1, 32'h200);
        vectors++;
        if (count !== 3'(mq.size())) begin miscompares++; $display("FAIL correct_count_push: got %0d want %0d", count, mq.size()); end
        resolve(1'b1, 32'h200);
        exp_r = (sb.size() != 0) ? sb.pop_front() : '0;
        got = {actual_taken, actual_target, predicted_taken, mispredict, recover_pc, upd_pc, upd_taken};
        vectors++;
        if (actual_valid !== 1'b1 || upd_valid !== 1'b1 || got !== exp_r)
            begin miscompares++; $display("FAIL correct_resolve: valid=%b/%b got %h want %h", actual_valid, upd_valid, got, exp_r); end
        vectors++;
        if (exp_r.rpc !== 32'h200 || exp_r.mis !== 1'b0) begin miscompares++; $display("FAIL correct_model: got %h want rpc 200 mis 0", exp_r); end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        vectors++;
        if ({actual_valid, mispredict, upd_valid} !== 3'b000 || recover_pc !== 32'h200)
            begin miscompares++; $display("FAIL correct_pulse_hold: pulses=%b rpc=%h want 000 / 200", {actual_valid, mispredict, upd_valid}, recover_pc); end
    endtask

    task automatic test_dir_mispredict();
        push(32'h100, 1'b0, 32'h0);
        resolve(1'b1, 32'h180);
        exp_r = (sb.size() != 0) ? sb.pop_front() : '0;
        got = {actual_taken, actual_target, predicted_taken, mispredict, recover_pc, upd_pc, upd_taken};
        vectors++;
        if (actual_valid !== 1'b1 || got !== exp_r || mispredict !== 1'b1 || recover_pc !== 32'h180)
            begin miscompares++; $display("FAIL dir_mispredict: valid=%b got %h want %h", actual_valid, got, exp_r); end
        vectors++;
        if (count !== 3'd0) begin miscompares++; $display("FAIL dir_mispredict_count: got %0d want 0", count); end
    endtask

    task automatic test_flush();
        push(32'h104, 1'b1, 32'h300);
        push(32'h108, 1'b1, 32'h400);
        // Not-taken resolution of a taken prediction, with a wrong-path push alongside.
        drive(1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 1'b0, 32'h0);
        exp_r = (sb.size() != 0) ? sb.pop_front() : '0;
        got = {actual_taken, actual_target, predicted_taken, mispredict, recover_pc, upd_pc, upd_taken};
        vectors++;
        if (actual_valid !== 1'b1 || got !== exp_r || recover_pc !== 32'h108)
            begin miscompares++; $display("FAIL flush_resolve: valid=%b got %h want %h", actual_valid, got, exp_r); end
        vectors++;
        if (count !== 3'd0 || mq.size() != 0) begin miscompares++; $display("FAIL flush_count: got %0d want 0", count); end
        push(32'h10, 1'b1, 32'h20);
        resolve(1'b1, 32'h24);
        exp_r = (sb.size() != 0) ? sb.pop_front() : '0;
        got = {actual_taken, actual_target, predicted_taken, mispredict, recover_pc, upd_pc, upd_taken};
        vectors++;
        if (actual_valid !== 1'b1 || got !== exp_r || mispredict !== 1'b1 || recover_pc !== 32'h24)
            begin miscompares++; $display("FAIL target_mispredict: got %h want %h", got, exp_r); end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(i) * 32'h10, 1'b0, 32'h0);
        vectors++;
        if (count !== 3'd4 || push_ready !== 1'b0) begin miscompares++; $display("FAIL full_state: count=%0d ready=%b want 4/0", count, push_ready); end
        push(32'h2000, 1'b0, 32'h0);
        vectors++;
        if (count !== 3'd4) begin miscompares++; $display("FAIL full_drop: count=%0d want 4", count); end
        drive(1'b1, 32'h3000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        vectors++;
        if (count !== 3'd4 || push_ready !== 1'b0) begin miscompares++; $display("FAIL full_push_pop: count=%0d ready=%b want 4/0", count, push_ready); end
        exp_r = (sb.size() != 0) ? sb.pop_front() : '0;
        got = {actual_taken, actual_target, predicted_taken, mispredict, recover_pc, upd_pc, upd_taken};
        vectors++;
        if (actual_valid !== 1'b1 || got !== exp_r) begin miscompares++; $display("FAIL full_push_pop_res: got %h want %h", got, exp_r); end
        for (int i = 0; i < DEPTH; i++) begin
            resolve(1'b0, 32'h0);
            exp_r = (sb.size() != 0) ? sb.pop_front() : '0;
            got = {actual_taken, actual_target, predicted_taken, mispredict, recover_pc, upd_pc, upd_taken};
            vectors++;
            if (actual_valid !== 1'b1 || got !== exp_r)
                begin miscompares++; $display("FAIL full_drain_%0d: got %h want %h", i, got, exp_r); end
        end
        vectors++;
        if (count !== 3'd0 || push_ready !== 1'b1) begin miscompares++; $display("FAIL full_empty: count=%0d ready=%b want 0/1", count, push_ready); end
    endtask

    task automatic test_wrap();
        logic        rt;
        logic [31:0] rtgt;
        for (int i = 0; i < 10; i++) begin
            rt = 1'b0; rtgt = 32'h0;
            if (i >= 2) begin rt = mq[0].pt; rtgt = mq[0].tgt; end
            drive(1'b1, 32'h4000 + 32'(i) * 32'd4, 1'(i), 32'h5000 + 32'(i),
                  (i >= 2), rt, rtgt);
            if (i >= 2) begin
                exp_r = (sb.size() != 0) ? sb.pop_front() : '0;
                got = {actual_taken, actual_target, predicted_taken, mispredict, recover_pc, upd_pc, upd_taken};
                vectors++;
                if (actual_valid !== 1'b1 || got !== exp_r)
                    begin miscompares++; $display("FAIL wrap_%0d: got %h want %h", i, got, exp_r); end
            end
        end
        vectors++;
        if (count !== 3'(mq.size())) begin miscompares++; $display("FAIL wrap_count: got %0d want %0d", count, mq.size()); end
        for (int i = 0; i < 2; i++) begin
            resolve(mq[0].pt, mq[0].tgt);
            exp_r = (sb.size() != 0) ? sb.pop_front() : '0;
            got = {actual_taken, actual_target, predicted_taken, mispredict, recover_pc, upd_pc, upd_taken};
            vectors++;
            if (actual_valid !== 1'b1 || got !== exp_r)
                begin miscompares++; $display("FAIL wrap_drain_%0d: got %h want %h", i, got, exp_r); end
        end
    endtask

    task automatic test_underflow();
        resolve(1'b1, 32'h77);
        vectors++;
        if (actual_valid !== 1'b0 || upd_valid !== 1'b0 || mispredict !== 1'b0)
            begin miscompares++; $display("FAIL underflow_strobe: %b want 000", {actual_valid, upd_valid, mispredict}); end
        vectors++;
        if (err_underflow !== exp_err || exp_err !== 1'b1) begin miscompares++; $display("FAIL underflow_flag: got %b want 1", err_underflow); end
        push(32'h600, 1'b0, 32'h0);
        resolve(1'b0, 32'h0);
        exp_r = (sb.size() != 0) ? sb.pop_front() : '0;
        got = {actual_taken, actual_target, predicted_taken, mispredict, recover_pc, upd_pc, upd_taken};
        vectors++;
        if (err_underflow !== 1'b1 || actual_valid !== 1'b1 || got !== exp_r)
            begin miscompares++; $display("FAIL underflow_sticky: err=%b got %h want %h", err_underflow, got, exp_r); end
    endtask

    task automatic test_async_reset();
        push(32'h700, 1'b1, 32'h800);
        push(32'h704, 1'b1, 32'h804);
        push(32'h708, 1'b1, 32'h808);
        vectors++;
        if (count !== 3'd3) begin miscompares++; $display("FAIL areset_pre_count: got %0d want 3", count); end
        #2;
        reset = 1'b0;
        mq.delete(); sb.delete(); exp_err = 1'b0;
        #1;
        vectors++;
        if (count !== 3'd0 || push_ready !== 1'b1) begin miscompares++; $display("FAIL areset_count: count=%0d ready=%b want 0/1", count, push_ready); end
        vectors++;
        if ({err_underflow, actual_valid, mispredict, upd_valid, actual_taken, predicted_taken} !== 6'b0 ||
            recover_pc !== 32'h0 || actual_target !== 32'h0)
            begin miscompares++; $display("FAIL areset_outputs: flags=%b rpc=%h tgt=%h want 0", {err_underflow, actual_valid, mispredict, upd_valid, actual_taken, predicted_taken}, recover_pc, actual_target); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        push(32'h900, 1'b0, 32'h0);
        vectors++;
        if (count !== 3'd1) begin miscompares++; $display("FAIL areset_first_push: count=%0d want 1", count); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_correct();
        test_dir_mispredict();
        test_flush();
        test_full();
        test_wrap();
        test_underflow();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
